// File: rtl/ctrl_block.sv
// rtl/ctrl_block.sv - multicycle fetch/decode/exec control sequencer for the reduced RISC-V core
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   instr_req           fetch request (high in FETCH, low while rst is high)
//   instr_addr          fetch address, always equal to pc
//   instr_valid, instr  instruction word handshake, sampled only in FETCH
//   EQ                  datapath equality flag, sampled at the end of EXEC
//   rs1, rs2, rd        register-file addresses
//   ALUsrc, ALUctrl     operand-2 select (1 = ImmOp), ALU op (1 = subtract/compare)
//   ImmOp               sign-extended immediate
//   RegWrite            register-file write enable, high only during EXEC
//   pc                  current program counter
//   illegal             sticky unsupported-instruction flag

module ctrl_block #(
    parameter int A_WIDTH = 32,
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic               instr_req,
    output logic [A_WIDTH-1:0] instr_addr,
    input  logic               instr_valid,
    input  logic [31:0]        instr,
    input  logic               EQ,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [4:0]         rd,
    output logic               ALUsrc,
    output logic               ALUctrl,
    output logic [D_WIDTH-1:0] ImmOp,
    output logic               RegWrite,
    output logic [A_WIDTH-1:0] pc,
    output logic               illegal
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] ir;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               is_addi;
    logic               is_add;
    logic               is_bne;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_b;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

    assign instr_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // instr_req is gated by rst so the request is withdrawn the moment reset rises.
    always_comb begin
        state_nxt = state;
        instr_req = 1'b0;
        case (state)
            FETCH: begin
                instr_req = ~rst;
                if (instr_valid) begin
                    state_nxt = DECODE;
                end
            end
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Controls are registered in DECODE so they are stable for the whole EXEC cycle.
    // The IR stays valid through EXEC, so the branch decision re-decodes it there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir       <= '0;
            pc       <= '0;
            rs1      <= '0;
            rs2      <= '0;
            rd       <= '0;
            ALUsrc   <= 1'b0;
            ALUctrl  <= 1'b0;
            ImmOp    <= '0;
            RegWrite <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        ir <= instr;
                    end
                end
                DECODE: begin
                    rs1      <= (is_addi || is_add || is_bne) ? ir[19:15] : 5'd0;
                    rs2      <= (is_add || is_bne) ? ir[24:20] : 5'd0;
                    rd       <= (is_addi || is_add) ? ir[11:7] : 5'd0;
                    ALUsrc   <= is_addi;
                    ALUctrl  <= is_bne;
                    ImmOp    <= is_addi ? D_WIDTH'(imm_i) : (is_bne ? D_WIDTH'(imm_b) : '0);
                    RegWrite <= is_addi || is_add;
                    if (!(is_addi || is_add || is_bne)) begin
                        illegal <= 1'b1;
                    end
                end
                EXEC: begin
                    RegWrite <= 1'b0;
                    if (is_bne && !EQ) begin
                        pc <= pc + A_WIDTH'(imm_b);
                    end else begin
                        pc <= pc + A_WIDTH'(32'd4);
                    end
                end
                default: begin
                    RegWrite <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ctrl_block.md
# ctrl_block

Multicycle control sequencer for the reduced RISC-V core. It owns the program counter, fetches instructions over a request/valid handshake, and decodes them. It drives the register-file addresses, immediate and control strobes into the datapath block (rs1/rs2/rd, ALUsrc, ALUctrl, ImmOp, RegWrite), and consumes the datapath's EQ flag to resolve branches. It sits between instruction memory and the datapath, and is the producing end of the datapath's control interface.

## Interface
- A_WIDTH, 32, PC / instruction address width
- D_WIDTH, 32, datapath word width (ImmOp width)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_req  out  1  fetch request to instruction memory
- instr_addr  out  A_WIDTH  fetch address (= PC)
- instr_valid  in  1  instruction word valid this cycle
- instr  in  32  instruction word
- EQ  in  1  datapath ALU zero flag (operands equal)
- rs1, rs2, rd  out  5 each  register-file addresses
- ALUsrc  out  1  0 = register operand 2, 1 = ImmOp
- ALUctrl  out  1  0 = add, 1 = subtract/compare
- ImmOp  out  D_WIDTH  sign-extended immediate
- RegWrite  out  1  register-file write enable
- pc  out  A_WIDTH  current PC
- illegal  out  1  sticky flag: an unsupported instruction was decoded

## Operation
- FSM states: FETCH, DECODE, EXEC. Reset state FETCH.
- FETCH:
  - instr_req = 1, instr_addr = pc.
  - On instr_valid = 1, latch instr into IR and go to DECODE; otherwise stay in FETCH.
  - instr_valid is ignored outside FETCH.
- DECODE: decode IR and register all control outputs, which stay stable through EXEC. Go to EXEC.
- EXEC:
  - RegWrite is high for exactly this one cycle, for writing instructions only.
  - EQ is sampled at the end of this cycle.
  - pc is updated, then the FSM returns to FETCH.
- Supported instructions:
  - addi (opcode 0010011, f3 000): rs1 = IR[19:15], rd = IR[11:7], ImmOp = sext(IR[31:20]), ALUsrc = 1, ALUctrl = 0, RegWrite = 1.
  - add (opcode 0110011, f3 000, f7 0000000): rs1, rs2 = IR[24:20], rd, ALUsrc = 0, ALUctrl = 0, RegWrite = 1.
  - bne (opcode 1100011, f3 001): rs1, rs2, rd = 0, ImmOp = sext({IR[31], IR[7], IR[30:25], IR[11:8], 0}), ALUsrc = 0, ALUctrl = 1, RegWrite = 0.
- Next PC:
  - bne with EQ = 0: pc + ImmOp.
  - All other cases: pc + 4.
  - Arithmetic is modulo 2^A_WIDTH, and wrap-around is silent.
- Any other encoding is treated as a NOP: all controls are 0, illegal is set to 1 (it stays 1 until reset), and pc advances by 4.
- A write to rd = 0 is still issued as RegWrite = 1; the register file discards it.

## Timing
- Reset values, asserted immediately and asynchronously:
  - pc = 0, instr_addr = 0, IR = 0.
  - rs1 = rs2 = rd = 0, ALUsrc = 0, ALUctrl = 0, ImmOp = 0, RegWrite = 0, illegal = 0.
  - instr_req = 0 while rst is high.
- First cycle after rst deasserts: instr_req = 1, instr_addr = 0.
- Instruction latency: 3 cycles minimum (valid in the first FETCH cycle), plus one cycle per wait-state cycle in FETCH.
- instr_addr is stable for the whole FETCH wait period.
- RegWrite never asserts outside EXEC and never for two consecutive cycles.
- pc changes only on the EXEC→FETCH edge; the new instr_addr is visible in the following FETCH cycle.
- Reset mid-instruction (any state): abort immediately, discard IR, emit no write, restart at FETCH with pc 0.

## Test plan
- Reset: hold rst for 3 cycles → all outputs 0. Release → instr_req = 1, instr_addr = 0x0.
- addi x10,x0,5 (0x00500513) with instr_valid in the first FETCH cycle:
  - DECODE: rs1 = 0, rd = 10, ImmOp = 5, ALUsrc = 1, ALUctrl = 0.
  - EXEC: RegWrite = 1 for one cycle.
  - Next FETCH: instr_addr = 0x4.
- bne x10,x11,-8 (0xFEB51CE3) at pc 0x8:
  - EQ = 0 → ImmOp = 0xFFFFFFF8, ALUctrl = 1, RegWrite = 0, next instr_addr = 0x0.
  - Repeat with EQ = 1 → next instr_addr = 0xC.
- Wait states: hold instr_valid = 0 for 3 cycles → stay in FETCH, instr_addr constant, RegWrite = 0. Raise instr_valid → DECODE next cycle.
- Illegal and wrap:
  - Instruction 0x00000000 → illegal = 1, no RegWrite, pc + 4.
  - bne with imm -4 at pc 0 and EQ = 0 → pc = 0xFFFFFFFC; then addi → pc wraps to 0x0; illegal remains 1.
- Reset during EXEC of addi → RegWrite drops the same cycle, pc = 0, next fetch address 0x0.
